// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch stage.
// TIMEOUT_DEF is only present when FETCH_TIMEOUT_EN is defined.
package fetch_pkg;

  localparam int unsigned ADDR_W_DEF = 8;
  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned CNT_W_DEF  = 8;
`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned TIMEOUT_DEF = 15;
`endif

  // Instruction delivered when a fetch is aborted
  localparam logic [15:0] NOP_INS = 16'h0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic logic is_busy(input state_t s);
    return s != IDLE;
  endfunction

endpackage

// File: rtl/fetch_timer.sv
// WAIT-state watchdog for the fetch unit; only built when FETCH_TIMEOUT_EN is defined.
// expire is asserted on the LIMIT-th enabled cycle after the last clear.
`ifdef FETCH_TIMEOUT_EN
module fetch_timer #(
  parameter int unsigned LIMIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int unsigned CW = (LIMIT < 2) ? 1 : $clog2(LIMIT);

  logic [CW-1:0] count;

  assign expire = enable && (count == CW'(LIMIT - 1));

  // Saturates at LIMIT-1 so a held expire cannot wrap back to a short count
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && !expire) begin
      count <= count + CW'(1);
    end
  end

endmodule
`endif

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one RAM read per fetch pulse, one-deep request buffer.
// Defining FETCH_TIMEOUT_EN adds a WAIT timeout that aborts with a NOP and a sticky fetch_err.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
`ifdef FETCH_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rvalid,
  output logic [DATA_W-1:0] ins,
  output logic              ins_valid,
  output logic              busy,
  output logic [CNT_W-1:0]  fetch_cnt,
  output logic              fetch_err
);

  state_t            state;
  logic              pending;
  logic              got;
  logic [ADDR_W-1:0] pend_addr;
  logic              abort_c;

  // Strobes follow en in the same cycle so a stall never issues a read or a pulse
  assign mem_rd    = (state == REQ) && en;
  assign ins_valid = (state == DONE) && en;

`ifdef FETCH_TIMEOUT_EN
  logic expire;

  fetch_timer #(
    .LIMIT (TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (mem_rd),
    .enable ((state == WAIT) && !got),
    .expire (expire)
  );

  // A response arriving on the expiry cycle still wins
  assign abort_c = expire && !mem_rvalid;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_err <= 1'b0;
    end else if (abort_c) begin
      fetch_err <= 1'b1;
    end
  end
`else
  assign abort_c   = 1'b0;
  assign fetch_err = 1'b0;
`endif

  // Fetch FSM; mem_addr doubles as the address of the fetch in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mem_addr  <= '0;
      ins       <= DATA_W'(NOP_INS);
      busy      <= 1'b0;
      fetch_cnt <= '0;
      pending   <= 1'b0;
      pend_addr <= '0;
      got       <= 1'b0;
    end else begin
      if (fetch_req && is_busy(state) && !pending) begin
        pending   <= 1'b1;
        pend_addr <= pc;
      end

      case (state)
        IDLE: begin
          if (fetch_req && en) begin
            mem_addr <= pc;
            state    <= REQ;
            busy     <= 1'b1;
          end
        end

        REQ: begin
          if (en) begin
            state <= WAIT;
          end
        end

        WAIT: begin
          // RAM cannot be stalled, so data is captured even while en is low
          if (mem_rvalid) begin
            ins <= mem_rdata;
            got <= 1'b1;
          end
          if ((got || mem_rvalid) && en) begin
            state <= DONE;
          end else if (abort_c) begin
            ins   <= DATA_W'(NOP_INS);
            state <= DONE;
          end
        end

        DONE: begin
          got <= 1'b0;
          if (en) begin
            fetch_cnt <= fetch_cnt + CNT_W'(1);
            if (pending) begin
              // Buffered request goes next; a same-cycle request refills the slot
              mem_addr <= pend_addr;
              state    <= REQ;
              pending  <= fetch_req;
              if (fetch_req) begin
                pend_addr <= pc;
              end
            end else if (fetch_req) begin
              mem_addr <= pc;
              state    <= REQ;
              pending  <= 1'b0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run against a
// transaction-level model (accepted-address queue, response-data queue, in-flight count).
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        fetch_req = 1'b0;
  logic [7:0]  pc = '0;
  logic [7:0]  mem_addr;
  logic        mem_rd;
  logic [15:0] mem_rdata = '0;
  logic        mem_rvalid = 1'b0;
  logic [15:0] ins;
  logic        ins_valid;
  logic        busy;
  logic [7:0]  fetch_cnt;
  logic        fetch_err;

  int checks = 0;
  int errors = 0;

  logic [7:0]  rd_log[$];
  logic [15:0] iv_log[$];

  fetch_unit dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .fetch_req  (fetch_req),
    .pc         (pc),
    .mem_addr   (mem_addr),
    .mem_rd     (mem_rd),
    .mem_rdata  (mem_rdata),
    .mem_rvalid (mem_rvalid),
    .ins        (ins),
    .ins_valid  (ins_valid),
    .busy       (busy),
    .fetch_cnt  (fetch_cnt),
    .fetch_err  (fetch_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // One cycle: drive inputs after the falling edge, then sample and log strobes
  task automatic drive(input logic f, input logic [7:0] p, input logic e,
                       input logic rv, input logic [15:0] rd);
    @(negedge clk);
    fetch_req  = f;
    pc         = p;
    en         = e;
    mem_rvalid = rv;
    mem_rdata  = rd;
    #1;
    if (mem_rd) rd_log.push_back(mem_addr);
    if (ins_valid) iv_log.push_back(ins);
  endtask

  task automatic idle(input int n, input logic e);
    repeat (n) drive(1'b0, 8'h00, e, 1'b0, 16'h0000);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    rd_log.delete();
    iv_log.delete();
  endtask

  task automatic test_reset;
    do_reset();
    idle(1, 1'b1);
    checks++; if (ins !== 16'h0) begin errors++; $display("FAIL reset_ins: got %h expected 0000", ins); end
    checks++; if (ins_valid !== 1'b0) begin errors++; $display("FAIL reset_ins_valid: got %b expected 0", ins_valid); end
    checks++; if (mem_rd !== 1'b0) begin errors++; $display("FAIL reset_mem_rd: got %b expected 0", mem_rd); end
    checks++; if (mem_addr !== 8'h0) begin errors++; $display("FAIL reset_mem_addr: got %h expected 00", mem_addr); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (fetch_cnt !== 8'h0) begin errors++; $display("FAIL reset_fetch_cnt: got %0d expected 0", fetch_cnt); end
    checks++; if (fetch_err !== 1'b0) begin errors++; $display("FAIL reset_fetch_err: got %b expected 0", fetch_err); end
  endtask

  task automatic test_basic;
    do_reset();
    drive(1'b1, 8'h05, 1'b1, 1'b0, 16'h0);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_c0: got %b expected 0", busy); end
    drive(1'b0, 8'h00, 1'b1, 1'b0, 16'h0);
    checks++; if (mem_rd !== 1'b1) begin errors++; $display("FAIL basic_mem_rd_c1: got %b expected 1", mem_rd); end
    checks++; if (mem_addr !== 8'h05) begin errors++; $display("FAIL basic_mem_addr: got %h expected 05", mem_addr); end
    drive(1'b0, 8'h00, 1'b1, 1'b1, 16'hA123);
    checks++; if (mem_rd !== 1'b0) begin errors++; $display("FAIL basic_mem_rd_c2: got %b expected 0", mem_rd); end
    checks++; if (ins_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %b expected 0", ins_valid); end
    drive(1'b0, 8'h00, 1'b1, 1'b0, 16'h0);
    checks++; if (ins_valid !== 1'b1) begin errors++; $display("FAIL basic_ins_valid_c3: got %b expected 1", ins_valid); end
    checks++; if (ins !== 16'hA123) begin errors++; $display("FAIL basic_ins: got %h expected a123", ins); end
    idle(2, 1'b1);
    checks++; if (fetch_cnt !== 8'd1) begin errors++; $display("FAIL basic_fetch_cnt: got %0d expected 1", fetch_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_end: got %b expected 0", busy); end
    checks++; if (iv_log.size() != 1) begin errors++; $display("FAIL basic_pulses: got %0d expected 1", iv_log.size()); end
    // request while idle and disabled is dropped
    drive(1'b1, 8'h77, 1'b0, 1'b0, 16'h0);
    idle(4, 1'b1);
    checks++; if (rd_log.size() != 1) begin errors++; $display("FAIL drop_idle_reads: got %0d expected 1", rd_log.size()); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drop_idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_back_to_back;
    do_reset();
    drive(1'b1, 8'h10, 1'b1, 1'b0, 16'h0);
    idle(1, 1'b1);
    drive(1'b1, 8'h11, 1'b1, 1'b0, 16'h0);
    drive(1'b1, 8'h12, 1'b1, 1'b0, 16'h0);
    drive(1'b0, 8'h00, 1'b1, 1'b1, 16'hA001);
    idle(2, 1'b1);
    drive(1'b0, 8'h00, 1'b1, 1'b1, 16'hB002);
    idle(6, 1'b1);
    checks++; if (rd_log.size() != 2) begin errors++; $display("FAIL b2b_reads: got %0d expected 2", rd_log.size()); end
    if (rd_log.size() == 2) begin
      checks++; if (rd_log[0] !== 8'h10) begin errors++; $display("FAIL b2b_addr0: got %h expected 10", rd_log[0]); end
      checks++; if (rd_log[1] !== 8'h11) begin errors++; $display("FAIL b2b_addr1: got %h expected 11", rd_log[1]); end
    end
    checks++; if (iv_log.size() != 2) begin errors++; $display("FAIL b2b_pulses: got %0d expected 2", iv_log.size()); end
    if (iv_log.size() == 2) begin
      checks++; if (iv_log[0] !== 16'hA001) begin errors++; $display("FAIL b2b_ins0: got %h expected a001", iv_log[0]); end
      checks++; if (iv_log[1] !== 16'hB002) begin errors++; $display("FAIL b2b_ins1: got %h expected b002", iv_log[1]); end
    end
    checks++; if (fetch_cnt !== 8'd2) begin errors++; $display("FAIL b2b_fetch_cnt: got %0d expected 2", fetch_cnt); end
    checks++; if (mem_addr !== 8'h11) begin errors++; $display("FAIL b2b_addr_hold: got %h expected 11", mem_addr); end
  endtask

  task automatic test_en_stall;
    do_reset();
    drive(1'b1, 8'h20, 1'b1, 1'b0, 16'h0);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 16'h0);
    checks++; if (mem_rd !== 1'b0) begin errors++; $display("FAIL stall_req_rd: got %b expected 0", mem_rd); end
    drive(1'b0, 8'h00, 1'b1, 1'b0, 16'h0);
    checks++; if (mem_rd !== 1'b1) begin errors++; $display("FAIL stall_req_resume: got %b expected 1", mem_rd); end
    drive(1'b0, 8'h00, 1'b0, 1'b0, 16'h0);
    drive(1'b0, 8'h00, 1'b0, 1'b1, 16'h5A5A);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 16'h0);
    checks++; if (ins !== 16'h5A5A) begin errors++; $display("FAIL stall_ins: got %h expected 5a5a", ins); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL stall_busy: got %b expected 1", busy); end
    idle(1, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b0, 16'h0);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 16'h0);
    checks++; if (iv_log.size() != 0) begin errors++; $display("FAIL stall_no_pulse: got %0d expected 0", iv_log.size()); end
    drive(1'b0, 8'h00, 1'b1, 1'b0, 16'h0);
    checks++; if (ins_valid !== 1'b1) begin errors++; $display("FAIL stall_pulse: got %b expected 1", ins_valid); end
    idle(3, 1'b1);
    checks++; if (iv_log.size() != 1) begin errors++; $display("FAIL stall_pulse_count: got %0d expected 1", iv_log.size()); end
    checks++; if (fetch_cnt !== 8'd1) begin errors++; $display("FAIL stall_fetch_cnt: got %0d expected 1", fetch_cnt); end
  endtask

  task automatic test_reset_mid;
    do_reset();
    drive(1'b1, 8'h30, 1'b1, 1'b0, 16'h0);
    idle(2, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    drive(1'b0, 8'h00, 1'b1, 1'b1, 16'hFFFF);
    idle(4, 1'b1);
    checks++; if (ins !== 16'h0) begin errors++; $display("FAIL rstmid_ins: got %h expected 0000", ins); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    checks++; if (iv_log.size() != 0) begin errors++; $display("FAIL rstmid_pulses: got %0d expected 0", iv_log.size()); end
    checks++; if (fetch_cnt !== 8'd0) begin errors++; $display("FAIL rstmid_fetch_cnt: got %0d expected 0", fetch_cnt); end
  endtask

  task automatic test_wrap;
    do_reset();
    for (int i = 0; i < 256; i++) begin
      drive(1'b1, 8'(i), 1'b1, 1'b0, 16'h0);
      idle(1, 1'b1);
      drive(1'b0, 8'h00, 1'b1, 1'b1, 16'(i));
      idle(1, 1'b1);
      if (i == 254) begin
        idle(1, 1'b1);
        checks++; if (fetch_cnt !== 8'd255) begin errors++; $display("FAIL wrap_255: got %0d expected 255", fetch_cnt); end
      end
    end
    idle(1, 1'b1);
    checks++; if (fetch_cnt !== 8'd0) begin errors++; $display("FAIL wrap_zero: got %0d expected 0", fetch_cnt); end
    checks++; if (iv_log.size() != 256) begin errors++; $display("FAIL wrap_pulses: got %0d expected 256", iv_log.size()); end
  endtask

  task automatic test_timeout;
`ifdef FETCH_TIMEOUT_EN
    int n;
    do_reset();
    drive(1'b1, 8'h3F, 1'b1, 1'b0, 16'h0);
    idle(1, 1'b1);
    drive(1'b0, 8'h00, 1'b1, 1'b1, 16'hA5A5);
    idle(2, 1'b1);
    drive(1'b1, 8'h40, 1'b1, 1'b0, 16'h0);
    n = 0;
    while (!ins_valid && n < 40) begin
      idle(1, 1'b1);
      n++;
    end
    checks++; if (n != 17) begin errors++; $display("FAIL tmo_latency: got %0d expected 17", n); end
    checks++; if (ins !== 16'h0000) begin errors++; $display("FAIL tmo_nop: got %h expected 0000", ins); end
    checks++; if (fetch_err !== 1'b1) begin errors++; $display("FAIL tmo_err: got %b expected 1", fetch_err); end
    idle(2, 1'b1);
    drive(1'b1, 8'h41, 1'b1, 1'b0, 16'h0);
    idle(1, 1'b1);
    drive(1'b0, 8'h00, 1'b1, 1'b1, 16'h1357);
    idle(3, 1'b1);
    checks++; if (ins !== 16'h1357) begin errors++; $display("FAIL tmo_after_ins: got %h expected 1357", ins); end
    checks++; if (fetch_err !== 1'b1) begin errors++; $display("FAIL tmo_sticky: got %b expected 1", fetch_err); end
    checks++; if (fetch_cnt !== 8'd3) begin errors++; $display("FAIL tmo_fetch_cnt: got %0d expected 3", fetch_cnt); end
    do_reset();
    idle(1, 1'b1);
    checks++; if (fetch_err !== 1'b0) begin errors++; $display("FAIL tmo_rst_clear: got %b expected 0", fetch_err); end
`else
    do_reset();
    drive(1'b1, 8'h40, 1'b1, 1'b0, 16'h0);
    idle(40, 1'b1);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL nowait_busy: got %b expected 1", busy); end
    checks++; if (iv_log.size() != 0) begin errors++; $display("FAIL nowait_pulses: got %0d expected 0", iv_log.size()); end
    checks++; if (fetch_err !== 1'b0) begin errors++; $display("FAIL nowait_err: got %b expected 0", fetch_err); end
    drive(1'b0, 8'h00, 1'b1, 1'b1, 16'h2468);
    idle(3, 1'b1);
    checks++; if (iv_log.size() != 1) begin errors++; $display("FAIL nowait_late_pulse: got %0d expected 1", iv_log.size()); end
    checks++; if (ins !== 16'h2468) begin errors++; $display("FAIL nowait_ins: got %h expected 2468", ins); end
`endif
  endtask

  task automatic test_random;
    int inflight = 0;
    int inflight0;
    int rd_idx = 0;
    int resp_in = 0;
    int exp_cnt = 0;
    logic [7:0]  acc_q[$];
    logic [15:0] data_q[$];
    logic [15:0] exp_ins;
    logic f, e, rv, stray, drain;
    logic [7:0]  p;
    logic [15:0] rd;
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      drain = (cyc >= 2700);
      inflight0 = inflight;
      e = drain ? 1'b1 : ($urandom_range(0, 9) != 0);
      f = !drain && (inflight0 < 2) && ($urandom_range(0, 3) == 0);
      p = 8'($urandom);
      rd = 16'($urandom);
      rv = 1'b0;
      stray = 1'b0;
      if (resp_in > 0) begin
        resp_in--;
        if (resp_in == 0) rv = 1'b1;
      end else if (inflight0 == 0 && $urandom_range(0, 9) == 0) begin
        rv = 1'b1;
        stray = 1'b1;
      end
      drive(f, p, e, rv, rd);

      checks++; if (busy !== (inflight0 > 0)) begin errors++; $display("FAIL rnd_busy cyc %0d: got %b expected %b", cyc, busy, inflight0 > 0); end
      if (rv && !stray) data_q.push_back(rd);
      if (mem_rd) begin
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL rnd_rd_en cyc %0d: got en %b expected 1", cyc, e); end
        checks++;
        if (rd_idx >= acc_q.size()) begin
          errors++; $display("FAIL rnd_rd_extra cyc %0d: got read %h expected none", cyc, mem_addr);
        end else if (mem_addr !== acc_q[rd_idx]) begin
          errors++; $display("FAIL rnd_rd_addr cyc %0d: got %h expected %h", cyc, mem_addr, acc_q[rd_idx]);
        end
        rd_idx++;
        resp_in = $urandom_range(1, 4);
      end
      if (ins_valid) begin
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL rnd_iv_en cyc %0d: got en %b expected 1", cyc, e); end
        checks++;
        if (data_q.size() == 0) begin
          errors++; $display("FAIL rnd_iv_extra cyc %0d: got %h expected no pulse", cyc, ins);
        end else begin
          exp_ins = data_q.pop_front();
          if (ins !== exp_ins) begin errors++; $display("FAIL rnd_ins cyc %0d: got %h expected %h", cyc, ins, exp_ins); end
        end
        checks++; if (fetch_cnt !== 8'(exp_cnt)) begin errors++; $display("FAIL rnd_cnt cyc %0d: got %0d expected %0d", cyc, fetch_cnt, 8'(exp_cnt)); end
        if (inflight > 0) inflight--;
        exp_cnt++;
      end
      if (f && (inflight0 == 1 || (inflight0 == 0 && e))) begin
        acc_q.push_back(p);
        inflight++;
      end
    end
    checks++; if (inflight != 0) begin errors++; $display("FAIL rnd_drain: got %0d in flight expected 0", inflight); end
    checks++; if (rd_idx != acc_q.size()) begin errors++; $display("FAIL rnd_reads: got %0d expected %0d", rd_idx, acc_q.size()); end
    checks++; if (fetch_cnt !== 8'(exp_cnt)) begin errors++; $display("FAIL rnd_final_cnt: got %0d expected %0d", fetch_cnt, 8'(exp_cnt)); end
    checks++; if (data_q.size() != 0) begin errors++; $display("FAIL rnd_undelivered: got %0d expected 0", data_q.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_en_stall();
    test_reset_mid();
    test_wrap();
    test_timeout();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the control unit.
- Takes the control unit's fetch pulse and the current PC from the datapath, issues a single-beat read to instruction RAM, and waits a variable latency for read data.
- Captures the returned word and delivers it as `ins` with a one-cycle `ins_valid` pulse; `ins_valid` connects to the control unit's `en_ram_out`.
- Buffers one pending fetch request so that back-to-back fetch pulses are not lost.

Parameters:
- ADDR_W, 8, width of PC and RAM address.
- DATA_W, 16, instruction width.
- CNT_W, 8, width of completed-fetch counter.
- TIMEOUT, 15, WAIT-cycle limit before abort (used only with the optional feature).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  global enable; low = freeze progress.
- fetch_req  in  1  one-cycle fetch pulse from control unit (`en_fetch_pulse`).
- pc  in  ADDR_W  current PC from datapath, sampled on request acceptance.
- mem_addr  out  ADDR_W  read address to RAM.
- mem_rd  out  1  one-cycle read strobe to RAM.
- mem_rdata  in  DATA_W  RAM read data.
- mem_rvalid  in  1  RAM read data valid, one cycle.
- ins  out  DATA_W  fetched instruction, held until next capture.
- ins_valid  out  1  one-cycle pulse, ins is new (to control unit `en_ram_out`).
- busy  out  1  high in any state other than IDLE.
- fetch_cnt  out  CNT_W  number of ins_valid pulses since reset.
- fetch_err  out  1  sticky timeout flag (tied 0 without the optional feature).

Behaviour:
- Reset values: state=IDLE; ins=0, ins_valid=0, mem_rd=0, mem_addr=0, busy=0, fetch_cnt=0, fetch_err=0; internal pending=0, got=0.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - If fetch_req && en: addr_q<=pc, next REQ.
  - If fetch_req && !en: request dropped.
- REQ:
  - If en: mem_rd=1, mem_addr=addr_q for exactly one cycle, next WAIT.
  - If !en: mem_rd=0, hold in REQ.
- WAIT:
  - mem_rvalid captures mem_rdata into ins and sets got, regardless of en. RAM cannot be stalled.
  - Advance to DONE when (got || mem_rvalid) && en.
  - Minimum latency: rvalid is honoured only from the cycle after mem_rd. rvalid in IDLE/REQ/DONE is ignored and ins is unchanged.
- DONE:
  - ins_valid = en; got cleared.
  - If en: fetch_cnt+1 (wraps 2^CNT_W-1 -> 0), then next = pending ? REQ : IDLE.
  - If !en: hold in DONE.
- mem_addr holds its last value outside REQ; mem_rd is 0 outside REQ.
- Pending buffer (one deep):
  - fetch_req while busy with pending=0: pending<=1, pend_addr<=pc.
  - When leaving DONE with pending set: addr_q<=pend_addr, pending<=0.
  - A second request while pending=1 is dropped; the first pending request is kept.
  - fetch_req in the same cycle DONE exits to IDLE counts as a busy request, so it becomes pending, or is served via REQ if the FSM is going there.
- Latency with immediate RAM response and en=1: fetch_req at cycle 0 -> mem_rd at 1 -> rvalid at 2 -> ins_valid at 3.
- rst mid-operation: all state cleared next edge; an outstanding RAM response after reset is ignored.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- Defined:
  - Counter runs every cycle in WAIT while got=0; cleared on entry to WAIT.
  - When the count reaches TIMEOUT with no rvalid: fetch_err<=1 (sticky until rst), ins<=0 (NOP), next DONE.
  - ins_valid and fetch_cnt behave normally.
- Undefined:
  - WAIT lasts indefinitely; fetch_err constant 0; no counter logic.

Decomposition:
- Package fetch_pkg holds:
  - state typedef: IDLE=2'd0, REQ=2'd1, WAIT=2'd2, DONE=2'd3.
  - default ADDR_W/DATA_W/CNT_W constants.
  - NOP_INS=16'h0000.
- One natural sub-module, fetch_timer: WAIT timeout counter with clear, enable and expire output. Instantiated only under FETCH_TIMEOUT_EN.

Test Plan:
- Basic fetch, en=1: pc=8'h05, pulse fetch_req, RAM returns 16'hA123 one cycle after mem_rd -> mem_addr=8'h05 with mem_rd high 1 cycle; ins=16'hA123; ins_valid pulse 3 cycles after request; fetch_cnt=1.
- Back-to-back requests: fetch_req with pc=8'h10, then pc=8'h11 while in WAIT, then pc=8'h12 while pending -> exactly two reads (0x10, 0x11), 0x12 dropped; two ins_valid pulses; fetch_cnt=2.
- en low mid-fetch: drop en in WAIT, rvalid 16'h5A5A arrives while en=0 -> ins=16'h5A5A; no ins_valid until en returns, then exactly one pulse.
- Reset mid-operation: assert rst in WAIT, then rvalid 16'hFFFF -> ins=0, busy=0, ins_valid never pulses, fetch_cnt=0.
- Counter wrap: 256 fetches with CNT_W=8 -> fetch_cnt returns to 0.
- Timeout (FETCH_TIMEOUT_EN, TIMEOUT=15): fetch with no rvalid -> after 15 WAIT cycles fetch_err=1, ins=16'h0000, one ins_valid; fetch_err stays 1 through later good fetches until rst.
